cfg_ff_bank: RTL and testbench

CFG_FF_BANK -- requirements
Module: cfg_ff_bank

---
 rtl/cfg_ff_pkg.sv | 12 +
 rtl/cfg_ff_cell.sv | 26 ++
 rtl/cfg_ff_bank.sv | 76 +++++++
 tb/tb_cfg_ff_bank.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/cfg_ff_pkg.sv
// Shared mode encodings for the configurable flip-flop bank.
// Imported by the cell and the bank top.
package cfg_ff_pkg;

  typedef enum logic [1:0] {
    MODE_D    = 2'b00,
    MODE_T    = 2'b01,
    MODE_JK   = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

endpackage

// File: rtl/cfg_ff_cell.sv
// Next-state function for one channel register.
// Ports: q (current), din (D/T/J), kin (K), mode; q_next (combinational).
module cfg_ff_cell
  import cfg_ff_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] kin,
  input  mode_e            mode,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      MODE_D:    q_next = din;
      MODE_T:    q_next = q ^ din;
      MODE_JK:   q_next = (din & ~q) | (~kin & q);
      MODE_HOLD: q_next = q;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/cfg_ff_bank.sv
// Bank of CHANNELS registers with per-write D/T/JK/hold update.
// Ports: clk, s_reset (sync, low), wr_en/wr_ch/mode/din/kin, rd_sel; q_out, changed, toggle_cnt.
module cfg_ff_bank
  import cfg_ff_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int CH_W    = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             s_reset,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] kin,
  input  logic [CH_W-1:0]  rd_sel,
  output logic [WIDTH-1:0] q_out,
  output logic             changed,
  output logic [7:0]       toggle_cnt
);

  logic [WIDTH-1:0] bank_q [CHANNELS];
  logic [WIDTH-1:0] bank_d [CHANNELS];
  logic [WIDTH-1:0] nxt    [CHANNELS];
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic             changed_q, changed_d;
  logic [7:0]       cnt_q, cnt_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cell
    cfg_ff_cell #(
      .WIDTH (WIDTH)
    ) u_cell (
      .q      (bank_q[g]),
      .din    (din),
      .kin    (kin),
      .mode   (mode_e'(mode)),
      .q_next (nxt[g])
    );
  end

  always_comb begin
    bank_d    = bank_q;
    // Read samples the pre-update contents (read-before-write).
    q_out_d   = bank_q[rd_sel];
    changed_d = wr_en && (nxt[wr_ch] != bank_q[wr_ch]);
    cnt_d     = cnt_q;
    if (wr_en) begin
      bank_d[wr_ch] = nxt[wr_ch];
    end
    if (changed_d && cnt_q != 8'hFF) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!s_reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        bank_q[i] <= '0;
      end
      q_out_q   <= '0;
      changed_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      bank_q    <= bank_d;
      q_out_q   <= q_out_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign q_out      = q_out_q;
  assign changed    = changed_q;
  assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_cfg_ff_bank.sv
// Randomized and directed bench for cfg_ff_bank (WIDTH=8, CHANNELS=4).
// Compares every cycle against a behavioural model of the bank.
module tb_cfg_ff_bank;

  logic       clk = 1'b0;
  logic       s_reset;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [1:0] mode;
  logic [7:0] din;
  logic [7:0] kin;
  logic [1:0] rd_sel;
  logic [7:0] q_out;
  logic       changed;
  logic [7:0] toggle_cnt;

  int n_chk = 0;
  int n_err = 0;

  int m_bank [4];
  int m_q    = 0;
  int m_chg  = 0;
  int m_cnt  = 0;

  always #5 clk = ~clk;

  cfg_ff_bank #(
    .WIDTH    (8),
    .CHANNELS (4)
  ) dut (
    .clk        (clk),
    .s_reset    (s_reset),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .mode       (mode),
    .din        (din),
    .kin        (kin),
    .rd_sel     (rd_sel),
    .q_out      (q_out),
    .changed    (changed),
    .toggle_cnt (toggle_cnt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int next_val(input int q, input int md,
                                  input int d, input int k);
    int r;
    r = q;
    case (md)
      0: r = d;
      1: r = q ^ d;
      2: begin
        for (int i = 0; i < 8; i++) begin
          case ({d[i], k[i]})
            2'b00: r[i] = q[i];
            2'b01: r[i] = 1'b0;
            2'b10: r[i] = 1'b1;
            default: r[i] = ~q[i];
          endcase
        end
      end
      default: r = q;
    endcase
    return r & 8'hFF;
  endfunction

  task automatic cyc(input bit rst_n, input bit we, input int ch,
                     input int md, input int d, input int k,
                     input int rs);
    int nv;
    s_reset = rst_n;
    wr_en   = we;
    wr_ch   = ch[1:0];
    mode    = md[1:0];
    din     = d[7:0];
    kin     = k[7:0];
    rd_sel  = rs[1:0];
    @(posedge clk);
    if (!rst_n) begin
      foreach (m_bank[i]) m_bank[i] = 0;
      m_q   = 0;
      m_chg = 0;
      m_cnt = 0;
    end else begin
      m_q   = m_bank[rs];
      m_chg = 0;
      if (we) begin
        nv = next_val(m_bank[ch], md, d & 8'hFF, k & 8'hFF);
        if (nv != m_bank[ch]) begin
          m_chg = 1;
          if (m_cnt < 255) m_cnt++;
        end
        m_bank[ch] = nv;
      end
    end
    #1;
    chk("q_out", int'(q_out), m_q);
    chk("changed", int'(changed), m_chg);
    chk("toggle_cnt", int'(toggle_cnt), m_cnt);
  endtask

  initial begin
    foreach (m_bank[i]) m_bank[i] = 0;

    // Reset overrides a same-edge full-ones write.
    cyc(0, 1, 0, 0, 'hFF, 0, 0);
    cyc(0, 1, 2, 0, 'hFF, 0, 0);
    chk("rst_cnt", int'(toggle_cnt), 0);
    for (int c = 0; c < 4; c++) cyc(1, 0, 0, 0, 0, 0, c);
    cyc(1, 0, 0, 0, 0, 0, 3);
    chk("rst_q", int'(q_out), 'h00);

    // D-load then toggle on ch1.
    cyc(1, 1, 1, 0, 'hA5, 0, 1);
    chk("dt_chg1", int'(changed), 1);
    cyc(1, 1, 1, 1, 'h0F, 0, 1);
    chk("dt_qa5", int'(q_out), 'hA5);
    chk("dt_chg2", int'(changed), 1);
    chk("dt_cnt", int'(toggle_cnt), 2);
    cyc(1, 0, 1, 0, 0, 0, 1);
    chk("dt_qaa", int'(q_out), 'hAA);

    // JK on ch2.
    cyc(1, 1, 2, 0, 'hF0, 0, 2);
    cyc(1, 1, 2, 2, 'h3C, 'hC3, 2);
    cyc(1, 1, 2, 2, 'hFF, 'hFF, 2);
    chk("jk_3c", int'(q_out), 'h3C);
    cyc(1, 0, 2, 0, 0, 0, 2);
    chk("jk_c3", int'(q_out), 'hC3);

    // Isolation and hold on ch0.
    cyc(1, 1, 0, 0, 'h55, 0, 0);
    cyc(1, 1, 0, 3, 'hFF, 'hFF, 0);
    chk("hold_chg", int'(changed), 0);
    cyc(1, 0, 0, 0, 'hFF, 0, 0);
    chk("noen_chg", int'(changed), 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("iso_ch0", int'(q_out), 'h55);
    for (int c = 1; c < 4; c++) cyc(1, 0, 0, 0, 0, 0, c);

    // Same-value D-load reports no change.
    cyc(1, 1, 0, 0, 'h55, 0, 0);
    chk("same_chg", int'(changed), 0);

    // Read-before-write on ch3.
    cyc(1, 1, 3, 0, 'h7E, 0, 3);
    chk("rbw_old", int'(q_out), 'h00);
    cyc(1, 0, 3, 0, 0, 0, 3);
    chk("rbw_new", int'(q_out), 'h7E);

    // Unknown mode with writes disabled does nothing.
    s_reset = 1'b1;
    wr_en   = 1'b0;
    mode    = 2'bxx;
    @(posedge clk);
    #1;
    chk("xmode_chg", int'(changed), 0);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 39) != 0), $urandom_range(0, 1),
          $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 3));
    end

    // Counter saturation.
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 300; n++) cyc(1, 1, 0, 1, 'h01, 0, 0);
    chk("sat_255", int'(toggle_cnt), 255);
    for (int n = 0; n < 4; n++) cyc(1, 1, 0, 1, 'h01, 0, 0);
    chk("sat_hold", int'(toggle_cnt), 255);
    cyc(0, 1, 0, 1, 'h01, 0, 0);
    chk("sat_rst", int'(toggle_cnt), 0);
    cyc(1, 1, 0, 1, 'h01, 0, 0);
    chk("post_rst", int'(toggle_cnt), 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_q", int'(q_out), 'h01);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
